// File: rtl/xgemac_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the xge_mac pkt_tx_* interface among NUM_SRC sources.
// Re-frames sop/eop, honours pkt_tx_full, truncates over-length packets and reports status.
module xgemac_tx_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int DATA_W        = 64,
  parameter int MOD_W         = 3,
  parameter int MAX_PKT_WORDS = 1200
) (
  input  logic                         clk_156m25,
  input  logic                         reset_156m25_n,
  input  logic                         arb_en,
  input  logic [NUM_SRC-1:0]           src_req,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  input  logic [NUM_SRC-1:0]           src_val,
  input  logic [NUM_SRC-1:0]           src_sop,
  input  logic [NUM_SRC-1:0]           src_eop,
  input  logic [NUM_SRC*MOD_W-1:0]     src_mod,
  output logic [NUM_SRC-1:0]           src_rdy,
  output logic [DATA_W-1:0]            pkt_tx_data,
  output logic                         pkt_tx_val,
  output logic                         pkt_tx_sop,
  output logic                         pkt_tx_eop,
  output logic [MOD_W-1:0]             pkt_tx_mod,
  input  logic                         pkt_tx_full,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         busy,
  output logic                         proto_err,
  output logic                         trunc_err,
  output logic [31:0]                  tx_pkt_cnt
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   pick_hi, pick_lo, pick;
  logic            hi_vld, lo_vld, pick_vld;
  logic [CW-1:0]   word_cnt;
  logic            first_word, last_word;
  logic [DATA_W-1:0] sel_data;
  logic [MOD_W-1:0]  sel_mod;
  logic            sel_val, sel_sop, sel_eop;
  logic            rdy_g, accept;

  // Circular search: the lowest requester above ptr wins, otherwise wrap to the lowest at or below it.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        if (GW'(i) > ptr) begin
          pick_hi = GW'(i);
          hi_vld  = 1'b1;
        end else begin
          pick_lo = GW'(i);
          lo_vld  = 1'b1;
        end
      end
    end
    pick     = hi_vld ? pick_hi : pick_lo;
    pick_vld = hi_vld | lo_vld;
  end

  always_comb begin
    sel_data = '0;
    sel_mod  = '0;
    sel_val  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data = src_data[i*DATA_W +: DATA_W];
        sel_mod  = src_mod[i*MOD_W +: MOD_W];
        sel_val  = src_val[i];
        sel_sop  = src_sop[i];
        sel_eop  = src_eop[i];
      end
    end
  end

  // DRAIN ignores backpressure since drained words never reach the MAC.
  assign rdy_g  = (state == DRAIN) || ((state == XFER) && !pkt_tx_full);
  assign accept = sel_val && rdy_g;

  always_comb begin
    src_rdy = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == GW'(i)) src_rdy[i] = rdy_g;
    end
  end

  assign first_word = (word_cnt == '0);
  assign last_word  = (word_cnt == CW'(MAX_PKT_WORDS - 1));

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      ptr         <= GW'(NUM_SRC - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      word_cnt    <= '0;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      proto_err   <= 1'b0;
      trunc_err   <= 1'b0;
      tx_pkt_cnt  <= '0;
    end else begin
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      proto_err   <= 1'b0;
      trunc_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en && pick_vld) begin
            grant_id <= pick;
            word_cnt <= '0;
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            word_cnt    <= word_cnt + CW'(1);
            pkt_tx_val  <= 1'b1;
            pkt_tx_data <= sel_data;
            pkt_tx_sop  <= first_word;
            // Missing sop on the first word or a stray sop later: either way sop != first_word.
            proto_err   <= first_word ^ sel_sop;
            if (sel_eop) begin
              pkt_tx_eop <= 1'b1;
              pkt_tx_mod <= sel_mod;
              tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
              ptr        <= grant_id;
              busy       <= 1'b0;
              state      <= IDLE;
            end else if (last_word) begin
              pkt_tx_eop <= 1'b1;
              trunc_err  <= 1'b1;
              tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
              ptr        <= grant_id;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept && sel_eop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgemac_tx_arbiter.sv
// Randomised and directed bench for xgemac_tx_arbiter, checked every cycle against a packet-level model.
module tb_xgemac_tx_arbiter;
  localparam int NS = 4, DW = 64, MW = 3, MAXW = 8, GW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [MW-1:0] mod;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b1;
  logic               arb_en = 1'b0;
  logic [NS-1:0]      src_req = '0, src_val = '0, src_sop = '0, src_eop = '0;
  logic [NS*DW-1:0]   src_data = '0;
  logic [NS*MW-1:0]   src_mod = '0;
  logic [NS-1:0]      src_rdy;
  logic [DW-1:0]      pkt_tx_data;
  logic               pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [MW-1:0]      pkt_tx_mod;
  logic               pkt_tx_full = 1'b0;
  logic [GW-1:0]      grant_id;
  logic               busy, proto_err, trunc_err;
  logic [31:0]        tx_pkt_cnt;

  xgemac_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .MOD_W(MW), .MAX_PKT_WORDS(MAXW)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .arb_en(arb_en),
    .src_req(src_req), .src_data(src_data), .src_val(src_val), .src_sop(src_sop),
    .src_eop(src_eop), .src_mod(src_mod), .src_rdy(src_rdy),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
    .grant_id(grant_id), .busy(busy), .proto_err(proto_err), .trunc_err(trunc_err),
    .tx_pkt_cnt(tx_pkt_cnt)
  );

  int n_checks = 0, n_fail = 0;

  // Source-side packet queues
  word_t srcq[NS][$];
  bit    started[NS];
  int    gen_mode = 0, val_pct = 100;
  bit    rand_full = 0, rand_arb = 0;

  // Reference model: who owns the link, how many words it has sent, and what must appear next cycle
  bit          m_busy, m_drain;
  int          m_g, m_ptr, m_idx;
  int unsigned m_cnt;
  logic [DW-1:0] e_data;
  logic [MW-1:0] e_mod;
  logic        e_val, e_sop, e_eop, e_proto, e_trunc;

  // Observed-output logs for directed literal checks
  word_t outlog[$];
  int    outcyc[$];
  int    dut_grants[$];
  int    n_proto, n_trunc, cycle;
  bit    prev_busy;
  logic [NS-1:0] last_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_g = 0; m_ptr = NS - 1; m_idx = 0; m_cnt = 0;
    e_val = 0; e_data = '0; e_sop = 0; e_eop = 0; e_mod = '0; e_proto = 0; e_trunc = 0;
    prev_busy = 0;
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      started[i] = 0;
    end
  endtask

  task automatic clear_logs();
    outlog.delete(); outcyc.delete(); dut_grants.delete();
    n_proto = 0; n_trunc = 0;
  endtask

  task automatic make_pkt(input int s, input int len, input bit rnd, input logic [DW-1:0] base);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.data = rnd ? {$urandom, $urandom} : base + DW'(k);
      w.sop  = (k == 0);
      w.eop  = (k == len - 1);
      w.mod  = rnd ? MW'($urandom_range(0, 7)) : (w.eop ? 3'd5 : 3'd7);
      if (rnd && $urandom_range(0, 99) < 5) w.sop = ~w.sop;
      srcq[s].push_back(w);
    end
  endtask

  task automatic drive_inputs();
    word_t w;
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() == 0) begin
        if (gen_mode == 1 && $urandom_range(0, 99) < 30) make_pkt(i, $urandom_range(1, 11), 1, '0);
        if (gen_mode == 2) make_pkt(i, 2, 0, DW'(64'h1000 * (i + 1)));
      end
      if (srcq[i].size() > 0) begin
        w = srcq[i][0];
        src_req[i] = !started[i];
        src_val[i] = ($urandom_range(0, 99) < val_pct);
        src_data[i*DW +: DW] = w.data;
        src_sop[i] = w.sop;
        src_eop[i] = w.eop;
        src_mod[i*MW +: MW] = w.mod;
      end else begin
        src_req[i] = 0; src_val[i] = 0; src_sop[i] = 0; src_eop[i] = 0;
        src_data[i*DW +: DW] = '0;
        src_mod[i*MW +: MW] = '0;
      end
    end
    if (rand_full) pkt_tx_full = ($urandom_range(0, 99) < 20);
    if (rand_arb)  arb_en = ($urandom_range(0, 99) < 85);
  endtask

  task automatic step();
    word_t w;
    logic [NS-1:0] erdy, acc_p;
    bit found;
    @(negedge clk);
    drive_inputs();
    #3;
    erdy = '0;
    if (m_busy) erdy[m_g] = m_drain ? 1'b1 : !pkt_tx_full;
    chk("src_rdy", src_rdy, erdy);
    last_rdy = src_rdy;
    acc_p = src_rdy & src_val;
    e_val = 0; e_data = '0; e_sop = 0; e_eop = 0; e_mod = '0; e_proto = 0; e_trunc = 0;
    if (!m_busy) begin
      if (arb_en && src_req != '0) begin
        found = 0;
        for (int k = 1; k <= NS; k++) begin
          if (!found && src_req[(m_ptr + k) % NS]) begin
            m_g = (m_ptr + k) % NS;
            found = 1;
          end
        end
        m_ptr = m_g; m_busy = 1; m_idx = 0; m_drain = 0;
      end
    end else if (src_val[m_g] && erdy[m_g] && srcq[m_g].size() > 0) begin
      w = srcq[m_g][0];
      m_idx++;
      if (m_drain) begin
        if (w.eop) m_busy = 0;
      end else begin
        e_val   = 1;
        e_data  = w.data;
        e_sop   = (m_idx == 1);
        e_eop   = w.eop || (m_idx == MAXW);
        e_mod   = w.eop ? w.mod : '0;
        e_proto = (m_idx == 1) ? !w.sop : w.sop;
        e_trunc = !w.eop && (m_idx == MAXW);
        if (e_eop) m_cnt++;
        if (w.eop) m_busy = 0;
        else if (e_trunc) m_drain = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("pkt_tx_val", pkt_tx_val, e_val);
    chk("pkt_tx_data", pkt_tx_data, e_data);
    chk("pkt_tx_sop", pkt_tx_sop, e_sop);
    chk("pkt_tx_eop", pkt_tx_eop, e_eop);
    chk("pkt_tx_mod", pkt_tx_mod, e_mod);
    chk("proto_err", proto_err, e_proto);
    chk("trunc_err", trunc_err, e_trunc);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_g);
    chk("tx_pkt_cnt", tx_pkt_cnt, m_cnt);
    if (pkt_tx_val) begin
      outlog.push_back({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod});
      outcyc.push_back(cycle);
    end
    if (proto_err) n_proto++;
    if (trunc_err) n_trunc++;
    if (busy && !prev_busy) dut_grants.push_back(int'(grant_id));
    prev_busy = busy;
    for (int i = 0; i < NS; i++) begin
      if (acc_p[i] && srcq[i].size() > 0) begin
        void'(srcq[i].pop_front());
        started[i] = (srcq[i].size() > 0);
      end
    end
    cycle++;
  endtask

  function automatic bit pending();
    bit p = m_busy;
    for (int i = 0; i < NS; i++) if (srcq[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic drain(input int bound, input string name);
    int n = 0;
    while (pending() && n < bound) begin
      step();
      n++;
    end
    chk(name, (n < bound), 1);
    step();
    step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    gen_mode = 0; rand_full = 0; rand_arb = 0; val_pct = 100;
    arb_en = 1; pkt_tx_full = 0;
    src_req = '0; src_val = '0; src_sop = '0; src_eop = '0; src_data = '0; src_mod = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    clear_logs();
  endtask

  initial begin
    cycle = 0;
    model_reset();
    clear_logs();
    #1 rst_n = 0;
    #2;
    chk("reset pkt_tx_val", pkt_tx_val, 0);
    chk("reset busy", busy, 0);
    chk("reset tx_pkt_cnt", tx_pkt_cnt, 0);
    chk("reset grant_id", grant_id, 0);
    do_reset();

    // Two 4-word packets from sources 0 and 2
    make_pkt(0, 4, 0, 64'h100);
    make_pkt(2, 4, 0, 64'h200);
    drain(100, "timeout two_pkts");
    chk("two_pkts words", outlog.size(), 8);
    if (outlog.size() == 8) begin
      chk("two_pkts sop1", outlog[0].sop, 1);
      chk("two_pkts sop5", outlog[4].sop, 1);
      chk("two_pkts eop4", outlog[3].eop, 1);
      chk("two_pkts eop8", outlog[7].eop, 1);
      chk("two_pkts mod4", outlog[3].mod, 5);
      chk("two_pkts data5", outlog[4].data, 64'h200);
      chk("two_pkts gap", outcyc[4] - outcyc[3], 2);
    end
    chk("two_pkts cnt", tx_pkt_cnt, 2);

    // All sources saturated with 2-word packets
    do_reset();
    gen_mode = 2;
    for (int n = 0; n < 80 && dut_grants.size() < 5; n++) step();
    gen_mode = 0;
    drain(200, "timeout rr");
    chk("rr grants", dut_grants.size() >= 5, 1);
    if (dut_grants.size() >= 5) begin
      chk("rr seq", {dut_grants[0][7:0], dut_grants[1][7:0], dut_grants[2][7:0],
                     dut_grants[3][7:0], dut_grants[4][7:0]}, 40'h00_01_02_03_00);
    end

    // Backpressure for 5 cycles while word 3 of 8 is presented
    do_reset();
    begin
      int n = 0, stalls = 0;
      make_pkt(1, 8, 0, 64'h300);
      while (srcq[1].size() > 6 && n < 50) begin step(); n++; end
      pkt_tx_full = 1;
      repeat (5) begin
        step();
        if (last_rdy[1] == 1'b0) stalls++;
      end
      pkt_tx_full = 0;
      chk("stall cycles", stalls, 5);
    end
    drain(100, "timeout stall");
    chk("stall words", outlog.size(), 8);
    for (int k = 0; k < 8 && k < outlog.size(); k++) chk("stall order", outlog[k].data, 64'h300 + k);

    // 12-word packet against an 8-word limit
    do_reset();
    make_pkt(3, 12, 0, 64'h400);
    drain(100, "timeout trunc");
    chk("trunc words", outlog.size(), 8);
    if (outlog.size() == 8) begin
      chk("trunc eop", outlog[7].eop, 1);
      chk("trunc mod", outlog[7].mod, 0);
    end
    chk("trunc pulses", n_trunc, 1);
    chk("trunc cnt", tx_pkt_cnt, 1);

    // Missing sop on word 1, stray sop on word 3
    do_reset();
    begin
      word_t w;
      for (int k = 0; k < 5; k++) begin
        w.data = 64'h500 + k; w.sop = (k == 2); w.eop = (k == 4); w.mod = 3'd2;
        srcq[0].push_back(w);
      end
    end
    drain(100, "timeout proto");
    chk("proto pulses", n_proto, 2);
    if (outlog.size() == 5) begin
      chk("proto sop1", outlog[0].sop, 1);
      chk("proto sop3", outlog[2].sop, 0);
    end

    // Asynchronous reset mid-packet, then priority restarts at source 0
    do_reset();
    make_pkt(1, 8, 0, 64'h600);
    for (int n = 0; n < 20 && outlog.size() < 2; n++) step();
    #2 rst_n = 0;
    #1;
    chk("areset val", pkt_tx_val, 0);
    chk("areset busy", busy, 0);
    chk("areset rdy", src_rdy, 0);
    chk("areset grant", grant_id, 0);
    chk("areset cnt", tx_pkt_cnt, 0);
    chk("areset data", pkt_tx_data, 0);
    do_reset();
    for (int i = NS - 1; i >= 0; i--) make_pkt(i, 1, 0, DW'(64'h700 + i));
    drain(100, "timeout post_reset");
    chk("post_reset first", (dut_grants.size() > 0) ? dut_grants[0] : -1, 0);

    // Random traffic: gaps, backpressure, arb_en toggling, framing errors, truncations
    do_reset();
    gen_mode = 1; rand_full = 1; rand_arb = 1; val_pct = 80;
    repeat (3000) step();
    gen_mode = 0; rand_full = 0; rand_arb = 0; arb_en = 1; pkt_tx_full = 0;
    drain(3000, "timeout random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xgemac_tx_arbiter.md
Name: xgemac_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single xge_mac transmit packet interface (pkt_tx_*) among NUM_SRC requesters.
- Sits in the clk_156m25 domain directly in front of xge_mac. Re-frames sop/eop, honours pkt_tx_full backpressure and truncates over-length packets.
- Reports grant, busy, protocol-error and packet-count status.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- DATA_W, 64, packet data width
- MOD_W, 3, byte-valid modulo width on the eop word
- MAX_PKT_WORDS, 1200, maximum words per packet before forced truncation

Ports:
- clk_156m25  in  1  system clock
- reset_156m25_n  in  1  asynchronous active-low reset
- arb_en  in  1  when 0, no new grants are issued; the packet in flight completes
- src_req  in  NUM_SRC  per-source request; level, held until its packet starts
- src_data  in  NUM_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
- src_val  in  NUM_SRC  per-source word valid
- src_sop  in  NUM_SRC  per-source start of packet
- src_eop  in  NUM_SRC  per-source end of packet
- src_mod  in  NUM_SRC*MOD_W  per-source modulo, valid with eop
- src_rdy  out  NUM_SRC  per-source word accept
- pkt_tx_data  out  DATA_W  to MAC
- pkt_tx_val  out  1  to MAC
- pkt_tx_sop  out  1  to MAC
- pkt_tx_eop  out  1  to MAC
- pkt_tx_mod  out  MOD_W  to MAC
- pkt_tx_full  in  1  MAC TX FIFO full
- grant_id  out  $clog2(NUM_SRC)  currently or last granted source
- busy  out  1  high in XFER or DRAIN
- proto_err  out  1  one-cycle pulse on a sop/eop framing violation
- trunc_err  out  1  one-cycle pulse on a forced truncation
- tx_pkt_cnt  out  32  packets emitted to the MAC, wraps at 2^32

Behaviour:
- Reset values: all outputs 0. The round-robin pointer starts at NUM_SRC-1, so source 0 has first priority. State is IDLE.

States:
- IDLE: sampled when arb_en=1 and src_req!=0. Pick the first requesting source after the last grant (circular). Register grant_id and go to XFER next cycle. All src_rdy=0 in IDLE.
- XFER: src_rdy[grant_id] = !pkt_tx_full (combinational); all other src_rdy=0.
  - A word is accepted when src_val & src_rdy on the granted source.
  - On eop accept, go to IDLE next cycle. The pointer becomes grant_id.
- DRAIN: src_rdy[grant_id]=1 regardless of pkt_tx_full. Accepted words are discarded (no pkt_tx_val). Go to IDLE on an accepted src_eop.

Datapath:
- Output is registered with 1-cycle latency. On accept, the next cycle has pkt_tx_val=1 and pkt_tx_data equal to the accepted data; otherwise pkt_tx_val=0 and data/sop/eop/mod are held at 0.
- pkt_tx_sop is generated internally: 1 on the first accepted word of a grant.
- pkt_tx_mod is the source mod on eop words and 0 otherwise.

Word counter:
- Reset on grant; incremented per accepted word.
- If the accepted word is number MAX_PKT_WORDS and has no src_eop: emit it with pkt_tx_eop=1, pkt_tx_mod=0, pulse trunc_err, and go to DRAIN.
- A word carrying src_eop at exactly MAX_PKT_WORDS is normal and not truncated.

Framing check (the output is still re-framed; proto_err pulses in the cycle after accept):
- First word without src_sop: proto_err.
- src_sop on a non-first word: proto_err.
- Both violations in one word produce a single pulse.

Counting and boundaries:
- tx_pkt_cnt increments on every emitted pkt_tx_eop, including truncations.
- Single-word packet (sop=eop=1): one word, then IDLE. The minimum inter-packet gap is one IDLE cycle.
- Changes to src_req after the grant are ignored until IDLE. Deasserting arb_en mid-packet does not stop the packet.
- pkt_tx_full rising mid-packet: src_rdy drops in the same cycle. No words are lost and pkt_tx_val=0 while stalled.
- Reset mid-packet: immediate return to reset values. No eop is emitted; the MAC is reset in the same domain.

Test Plan:
- Sources 0 and 2 each request one 4-word packet, arb_en=1 -> src 0 packet, then src 2. pkt_tx_sop on words 1 and 5, eop on words 4 and 8. One idle cycle between packets; tx_pkt_cnt=2.
- All 4 sources continuously requesting 2-word packets -> grant_id sequence 0,1,2,3,0. No source is granted twice before the others.
- pkt_tx_full=1 for 5 cycles mid-packet (word 3 of 8) -> src_rdy low for exactly those cycles. All 8 words emitted in order with no duplicates.
- MAX_PKT_WORDS=8, source sends 12 words -> 8 words emitted, eop on word 8 with mod=0, trunc_err pulses once. The remaining 4 words are drained without pkt_tx_val; tx_pkt_cnt=1.
- First word without src_sop, then src_sop on word 3 -> two proto_err pulses. Output still carries sop on word 1 only.
- Assert reset_156m25_n low asynchronously during XFER -> all outputs 0 immediately. After release, source 0 wins the first grant.
